excp_ctrl: RTL

EXCP_CTRL -- requirements
Module: excp_ctrl

---
 rtl/excp_ctrl_if.sv | 19 +
 rtl/excp_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/excp_ctrl_if.sv
// Register access port of the exception controller.
// master drives the access, slave (excp_ctrl) returns read data.
interface excp_ctrl_if;
   logic        cfg_we;
   logic [13:0] cfg_addr;
   logic [31:0] cfg_wmask;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;

   modport master (
      output cfg_we, cfg_addr, cfg_wmask, cfg_wdata,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wmask, cfg_wdata,
      output cfg_rdata
   );
endinterface

// File: rtl/excp_ctrl.sv
// Exception/interrupt control registers with timer,
// exception/ERTN state update and redirect PC generation.
module excp_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exception_submit,
   input  logic [5:0]  ecode_submit,
   input  logic [8:0]  esubcode_submit,
   input  logic [31:0] exception_pc_submit,
   input  logic [31:0] exception_maddr_submit,
   input  logic        ertn_submit,
   input  logic [7:0]  hw_int,
   excp_ctrl_if.slave  cfg,
   output logic        has_interrupt,
   output logic [31:0] ex_entry
);

   localparam logic [13:0] A_CRMD   = 14'h00;
   localparam logic [13:0] A_PRMD   = 14'h01;
   localparam logic [13:0] A_ECFG   = 14'h04;
   localparam logic [13:0] A_ESTAT  = 14'h05;
   localparam logic [13:0] A_ERA    = 14'h06;
   localparam logic [13:0] A_BADV   = 14'h07;
   localparam logic [13:0] A_EENTRY = 14'h0C;
   localparam logic [13:0] A_TID    = 14'h40;
   localparam logic [13:0] A_TCFG   = 14'h41;
   localparam logic [13:0] A_TVAL   = 14'h42;
   localparam logic [13:0] A_TICLR  = 14'h44;

   logic [1:0]  plv, pplv;
   logic        ie, pie, da;
   logic [12:0] lie;
   logic [1:0]  is_sw;
   logic [7:0]  is_hw;
   logic        is_ti;
   logic [5:0]  ecode;
   logic [8:0]  esubcode;
   logic [31:0] era, badv, tid, tval;
   logic [25:0] eentry_va;
   logic        tcfg_en, tcfg_per;
   logic [29:0] tcfg_init;

   logic [31:0] wd, wm;
   logic [31:0] crmd_q, prmd_q, estat_q, tcfg_q;
   logic [3:0]  crmd_w;
   logic [2:0]  prmd_w;
   logic [12:0] ecfg_w;
   logic [1:0]  estat_w;
   logic [31:0] era_w, badv_w, tid_w, tcfg_w;
   logic [25:0] eentry_w;
   logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat;
   logic        wr_era, wr_badv, wr_eentry, wr_tid;
   logic        wr_tcfg, wr_ticlr;
   logic        tmr_fire, ticlr_hit, badv_exc;

   assign wd = cfg.cfg_wdata;
   assign wm = cfg.cfg_wmask;

   assign crmd_q  = {28'b0, da, ie, plv};
   assign prmd_q  = {29'b0, pie, pplv};
   assign estat_q = {1'b0, esubcode, ecode, 3'b0,
                     1'b0, is_ti, 1'b0, is_hw, is_sw};
   assign tcfg_q  = {tcfg_init, tcfg_per, tcfg_en};

   assign crmd_w   = (crmd_q[3:0] & ~wm[3:0]) | (wd[3:0] & wm[3:0]);
   assign prmd_w   = (prmd_q[2:0] & ~wm[2:0]) | (wd[2:0] & wm[2:0]);
   assign ecfg_w   = (lie & ~wm[12:0]) | (wd[12:0] & wm[12:0]);
   assign estat_w  = (is_sw & ~wm[1:0]) | (wd[1:0] & wm[1:0]);
   assign era_w    = (era & ~wm) | (wd & wm);
   assign badv_w   = (badv & ~wm) | (wd & wm);
   assign tid_w    = (tid & ~wm) | (wd & wm);
   assign tcfg_w   = (tcfg_q & ~wm) | (wd & wm);
   assign eentry_w = (eentry_va & ~wm[31:6]) | (wd[31:6] & wm[31:6]);

   assign wr_crmd   = cfg.cfg_we & (cfg.cfg_addr == A_CRMD);
   assign wr_prmd   = cfg.cfg_we & (cfg.cfg_addr == A_PRMD);
   assign wr_ecfg   = cfg.cfg_we & (cfg.cfg_addr == A_ECFG);
   assign wr_estat  = cfg.cfg_we & (cfg.cfg_addr == A_ESTAT);
   assign wr_era    = cfg.cfg_we & (cfg.cfg_addr == A_ERA);
   assign wr_badv   = cfg.cfg_we & (cfg.cfg_addr == A_BADV);
   assign wr_eentry = cfg.cfg_we & (cfg.cfg_addr == A_EENTRY);
   assign wr_tid    = cfg.cfg_we & (cfg.cfg_addr == A_TID);
   assign wr_tcfg   = cfg.cfg_we & (cfg.cfg_addr == A_TCFG);
   assign wr_ticlr  = cfg.cfg_we & (cfg.cfg_addr == A_TICLR);

   assign tmr_fire  = ~wr_tcfg & tcfg_en & (tval == 32'd0);
   assign ticlr_hit = wr_ticlr & wd[0] & wm[0];
   assign badv_exc  = (ecode_submit == 6'h08) | (ecode_submit == 6'h09);

   // register state: cfg writes first, event updates override them
   always_ff @(posedge clk) begin
      if (!resetn) begin
         plv       <= 2'b0;
         ie        <= 1'b0;
         da        <= 1'b1;
         pplv      <= 2'b0;
         pie       <= 1'b0;
         lie       <= 13'b0;
         is_sw     <= 2'b0;
         is_hw     <= 8'b0;
         is_ti     <= 1'b0;
         ecode     <= 6'b0;
         esubcode  <= 9'b0;
         era       <= 32'b0;
         badv      <= 32'b0;
         eentry_va <= 26'b0;
         tid       <= 32'b0;
         tcfg_en   <= 1'b0;
         tcfg_per  <= 1'b0;
         tcfg_init <= 30'b0;
         tval      <= 32'b0;
      end else begin
         is_hw <= hw_int;
         if (wr_crmd) {da, ie, plv} <= crmd_w;
         if (wr_prmd) {pie, pplv} <= prmd_w;
         if (wr_ecfg) lie <= ecfg_w;
         if (wr_estat) is_sw <= estat_w;
         if (wr_era) era <= era_w;
         if (wr_badv) badv <= badv_w;
         if (wr_eentry) eentry_va <= eentry_w;
         if (wr_tid) tid <= tid_w;
         if (ticlr_hit) is_ti <= 1'b0;
         if (wr_tcfg) begin
            {tcfg_init, tcfg_per, tcfg_en} <= tcfg_w;
            tval <= {tcfg_w[31:2], 2'b00};
         end else if (tcfg_en) begin
            if (tval != 32'd0) begin
               tval <= tval - 32'd1;
            end else begin
               is_ti <= 1'b1;
               if (tcfg_per) tval <= {tcfg_init, 2'b00};
               else tcfg_en <= 1'b0;
            end
         end
         if (exception_submit) begin
            pplv     <= plv;
            pie      <= ie;
            plv      <= 2'b0;
            ie       <= 1'b0;
            era      <= exception_pc_submit;
            ecode    <= ecode_submit;
            esubcode <= esubcode_submit;
            if (badv_exc) badv <= exception_maddr_submit;
         end else if (ertn_submit) begin
            plv <= pplv;
            ie  <= pie;
         end
      end
   end

   // combinational register read mux
   always_comb begin
      cfg.cfg_rdata = 32'b0;
      case (cfg.cfg_addr)
         A_CRMD:   cfg.cfg_rdata = crmd_q;
         A_PRMD:   cfg.cfg_rdata = prmd_q;
         A_ECFG:   cfg.cfg_rdata = {19'b0, lie};
         A_ESTAT:  cfg.cfg_rdata = estat_q;
         A_ERA:    cfg.cfg_rdata = era;
         A_BADV:   cfg.cfg_rdata = badv;
         A_EENTRY: cfg.cfg_rdata = {eentry_va, 6'b0};
         A_TID:    cfg.cfg_rdata = tid;
         A_TCFG:   cfg.cfg_rdata = tcfg_q;
         A_TVAL:   cfg.cfg_rdata = tval;
         default:  cfg.cfg_rdata = 32'b0;
      endcase
   end

   // redirect target and interrupt request
   always_comb begin
      ex_entry = {eentry_va, 6'b0};
      if (!exception_submit && ertn_submit) ex_entry = era;
      has_interrupt = ie & |(estat_q[12:0] & lie);
   end

endmodule
